mem_access_ctrl: RTL and testbench

Processor-side initiator for the unified instruction/data memory. Accepts instruction-fetch requests from the fetch stage and load/store requests from the memory stage, serialises them onto the memory's `ReadPC` / `ReadWriteAddr` / `DataWrite` / `Op2En` / `Op2RW` port, and returns `Instruction` / `Data` to the requester with a one-cycle completion pulse. It sits between the pipeline stages and the memory block, and is the only driver of the memory's control inputs.

---
 rtl/mem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Serialises instruction fetches and loads/stores from the pipeline onto the
// unified memory port and returns results with a one-cycle completion pulse.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ReadPC,
  output logic [ADDR_W-1:0] ReadWriteAddr,
  output logic [DATA_W-1:0] DataWrite,
  output logic              Op2En,
  output logic              Op2RW,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] Data
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
    $error("mem_access_ctrl: MEM_LAT=%0d outside legal range 1..7", MEM_LAT);
  end

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_cnt;
  logic              r_last_data;   // 1 = the most recently completed access was a data access
  logic              r_kind_data;   // 1 = current access is a load/store, 0 = fetch
  logic              r_we;
  logic [ADDR_W-1:0] r_read_pc;
  logic [ADDR_W-1:0] r_rw_addr;
  logic [DATA_W-1:0] r_data_write;
  logic [DATA_W-1:0] r_if_instr;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_any_req;
  logic w_grant_data;

  assign w_any_req    = if_req | ls_req;
  // On a tie, the kind that was not served last wins.
  assign w_grant_data = ls_req & (~if_req | ~r_last_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if_ready     = 1'b0;
    ls_done      = 1'b0;
    Op2En        = 1'b0;
    Op2RW        = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        Op2En = r_kind_data;
        Op2RW = r_kind_data & r_we;
        if (r_kind_data && r_we) begin
          w_state_next = RESP;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        Op2En = r_kind_data & ~r_we;
        if (r_cnt <= 3'd1) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if_ready     = ~r_kind_data;
        ls_done      = r_kind_data;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 3'd0;
      r_last_data  <= 1'b0;
      r_kind_data  <= 1'b0;
      r_we         <= 1'b0;
      r_read_pc    <= '0;
      r_rw_addr    <= '0;
      r_data_write <= '0;
      r_if_instr   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Port registers are loaded at grant so they are already valid in ISSUE.
          if (w_any_req) begin
            r_kind_data <= w_grant_data;
            if (w_grant_data) begin
              r_we      <= ls_we;
              r_rw_addr <= ls_addr;
              if (ls_we) begin
                r_data_write <= ls_wdata;
              end
            end else begin
              r_we      <= 1'b0;
              r_read_pc <= if_pc;
            end
          end
        end
        ISSUE: begin
          if (!(r_kind_data && r_we)) begin
            r_cnt <= LAT;
          end
        end
        WAIT: begin
          if (r_cnt <= 3'd1) begin
            if (r_kind_data) begin
              r_ls_rdata <= Data;
            end else begin
              r_if_instr <= Instruction;
            end
          end
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_last_data <= r_kind_data;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign ReadPC        = r_read_pc;
  assign ReadWriteAddr = r_rw_addr;
  assign DataWrite     = r_data_write;
  assign if_instr      = r_if_instr;
  assign ls_rdata      = r_ls_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT 1 and 3), each with its own
// word memory; directed vectors, corner sequences and a cycle-level random model.
module tb_mem_access_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_load;
  logic        if_req   [2];
  logic [31:0] if_pc    [2];
  logic        if_ready [2];
  logic [31:0] if_instr [2];
  logic        ls_req   [2];
  logic        ls_we    [2];
  logic [31:0] ls_addr  [2];
  logic [31:0] ls_wdata [2];
  logic        ls_done  [2];
  logic [31:0] ls_rdata [2];
  logic        busy     [2];
  logic [31:0] read_pc  [2];
  logic [31:0] rw_addr  [2];
  logic [31:0] data_wr  [2];
  logic        op2en    [2];
  logic        op2rw    [2];
  logic [31:0] instr_in [2];
  logic [31:0] data_in  [2];

  logic [31:0] mem       [2][16];
  logic [31:0] model_mem [2][16];

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_pc(if_pc[0]), .if_ready(if_ready[0]), .if_instr(if_instr[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
    .ls_done(ls_done[0]), .ls_rdata(ls_rdata[0]), .busy(busy[0]),
    .ReadPC(read_pc[0]), .ReadWriteAddr(rw_addr[0]), .DataWrite(data_wr[0]),
    .Op2En(op2en[0]), .Op2RW(op2rw[0]), .Instruction(instr_in[0]), .Data(data_in[0])
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_pc(if_pc[1]), .if_ready(if_ready[1]), .if_instr(if_instr[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
    .ls_done(ls_done[1]), .ls_rdata(ls_rdata[1]), .busy(busy[1]),
    .ReadPC(read_pc[1]), .ReadWriteAddr(rw_addr[1]), .DataWrite(data_wr[1]),
    .Op2En(op2en[1]), .Op2RW(op2rw[1]), .Instruction(instr_in[1]), .Data(data_in[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h2008_0005;
    if (i == 1) return 32'h0000_00AA;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Word memories with one-cycle registered read; writes commit on Op2En & Op2RW.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_load) begin
        for (int i = 0; i < 16; i++) mem[d][i] <= init_word(i);
      end else if (op2en[d] && op2rw[d]) begin
        mem[d][rw_addr[d][3:0]] <= data_wr[d];
      end
      data_in[d]  <= mem[d][rw_addr[d][3:0]];
      instr_in[d] <= mem[d][read_pc[d][3:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One access from an idle DUT; entered and left just after a rising edge (cycle 0).
  task automatic do_access(input int d, input bit fetch, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int pulse_k, output int pulses, output int en_cnt,
                           output int rw_cnt, output logic [31:0] got,
                           output logic [31:0] port_addr, output logic [31:0] dw_c1,
                           output logic en_c1);
    pulse_k = -1; pulses = 0; en_cnt = 0; rw_cnt = 0;
    got = '0; port_addr = '0; dw_c1 = '0; en_c1 = 1'b0;
    if (fetch) begin
      if_pc[d] = addr; if_req[d] = 1'b1;
    end else begin
      ls_addr[d] = addr; ls_we[d] = we; ls_wdata[d] = wdata; ls_req[d] = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (op2en[d]) en_cnt++;
      if (op2en[d] && op2rw[d]) rw_cnt++;
      if (k == 1) begin
        port_addr = fetch ? read_pc[d] : rw_addr[d];
        dw_c1     = data_wr[d];
        en_c1     = op2en[d];
      end
      if (if_ready[d] || ls_done[d]) begin
        pulses += ((fetch ? if_ready[d] : ls_done[d]) && !(fetch ? ls_done[d] : if_ready[d])) ? 1 : 100;
        if (pulse_k < 0) begin
          pulse_k = k;
          got = fetch ? if_instr[d] : ls_rdata[d];
        end
        @(posedge clk); #1;
        if_req[d] = 1'b0; ls_req[d] = 1'b0;
      end
    end
    if_req[d] = 1'b0; ls_req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          d;
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_pulse;
    int          exp_en;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pk, np, enc, rwc, seen_k[$], seen_data[$];
    logic [31:0] got, pa, dw;
    logic        e1;
    int          pulse_cnt;
    // random-phase model state
    bit          f_pend, d_pend, f_rel, d_rel, d_we, last_data, cur_data, cur_we;
    logic [31:0] f_pc, d_addr, d_wdata, cur_addr, cur_wdata, exp_val;
    int          next_idle, grant, done;

    vecs[0] = '{0, 0, 0, 32'd1, 32'h0,         32'h0000_00AA, 3, 2};
    vecs[1] = '{0, 0, 1, 32'd2, 32'hDEAD_BEEF, 32'h0,         2, 1};
    vecs[2] = '{0, 0, 0, 32'd2, 32'h0,         32'hDEAD_BEEF, 3, 2};
    vecs[3] = '{0, 1, 0, 32'd0, 32'h0,         32'h2008_0005, 3, 0};
    vecs[4] = '{0, 0, 1, 32'd7, 32'h0BAD_F00D, 32'h0,         2, 1};
    vecs[5] = '{0, 1, 0, 32'd7, 32'h0,         32'h0BAD_F00D, 3, 0};
    vecs[6] = '{1, 0, 0, 32'd1, 32'h0,         32'h0000_00AA, 5, 4};
    vecs[7] = '{1, 0, 1, 32'd3, 32'hCAFE_F00D, 32'h0,         2, 1};
    vecs[8] = '{1, 0, 0, 32'd3, 32'h0,         32'hCAFE_F00D, 5, 4};
    vecs[9] = '{1, 1, 0, 32'd3, 32'h0,         32'hCAFE_F00D, 5, 0};

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) model_mem[d][i] = init_word(i);
      if_req[d] = 0; if_pc[d] = 0; ls_req[d] = 0; ls_we[d] = 0; ls_addr[d] = 0; ls_wdata[d] = 0;
    end
    rst_n = 1'b0;
    mem_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_load = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_if_ready", 32'(if_ready[d]), 0);
      chk("rst_ls_done", 32'(ls_done[d]), 0);
      chk("rst_op2en", 32'(op2en[d]), 0);
      chk("rst_op2rw", 32'(op2rw[d]), 0);
      chk("rst_readpc", read_pc[d], 0);
      chk("rst_rwaddr", rw_addr[d], 0);
      chk("rst_datawrite", data_wr[d], 0);
      chk("rst_if_instr", if_instr[d], 0);
      chk("rst_ls_rdata", ls_rdata[d], 0);
    end

    // Arbitration: both requests held from reset -> data, fetch, data, fetch.
    if_req[0] = 1; if_pc[0] = 0; ls_req[0] = 1; ls_we[0] = 0; ls_addr[0] = 1;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_cnt = 0;
    for (int k = 1; k <= 40 && pulse_cnt < 4; k++) begin
      @(negedge clk);
      if (ls_done[0]) begin seen_k.push_back(k); seen_data.push_back(1); pulse_cnt++; end
      if (if_ready[0]) begin seen_k.push_back(k); seen_data.push_back(0); pulse_cnt++; end
      if (ls_done[0]) chk("arb_ls_rdata", ls_rdata[0], 32'h0000_00AA);
      if (if_ready[0]) chk("arb_if_instr", if_instr[0], 32'h2008_0005);
    end
    @(posedge clk); #1;
    if_req[0] = 0; ls_req[0] = 0;
    chk("arb_pulse_count", 32'(seen_k.size()), 4);
    for (int i = 0; i < 4 && i < seen_k.size(); i++) begin
      chk("arb_kind", 32'(seen_data[i]), 32'((i % 2) == 0));
      chk("arb_cycle", 32'(seen_k[i]), 32'(3 + 4 * i));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arb_quiet", {29'd0, busy[0], if_ready[0], ls_done[0]}, 0);
    end
    @(posedge clk); #1;

    // Directed single accesses on both latencies.
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].d, vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                pk, np, enc, rwc, got, pa, dw, e1);
      $display("vec %0d dut%0d fetch=%0d we=%0d addr=%0d pulse@%0d data=%h", i,
               vecs[i].d, vecs[i].fetch, vecs[i].we, vecs[i].addr, pk, got);
      chk("vec_pulse_cycle", 32'(pk), 32'(vecs[i].exp_pulse));
      chk("vec_pulse_once", 32'(np), 1);
      chk("vec_op2en_cycles", 32'(enc), 32'(vecs[i].exp_en));
      chk("vec_write_cycles", 32'(rwc), 32'(vecs[i].we));
      chk("vec_port_addr", pa, vecs[i].addr);
      chk("vec_op2en_issue", 32'(e1), 32'(!vecs[i].fetch));
      if (vecs[i].we) begin
        chk("vec_datawrite", dw, vecs[i].wdata);
        model_mem[vecs[i].d][vecs[i].addr[3:0]] = vecs[i].wdata;
      end else begin
        chk("vec_rdata", got, vecs[i].exp_data);
      end
    end

    // Reset in the middle of a MEM_LAT=3 load wait.
    ls_req[1] = 1; ls_we[1] = 0; ls_addr[1] = 1;
    repeat (3) @(negedge clk);
    chk("rstmid_in_wait", {30'd0, busy[1], op2en[1]}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    ls_req[1] = 0;
    chk("rstmid_op2en", 32'(op2en[1]), 0);
    chk("rstmid_busy", 32'(busy[1]), 0);
    chk("rstmid_ls_rdata", ls_rdata[1], 0);
    chk("rstmid_rwaddr", rw_addr[1], 0);
    pulse_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pulse_cnt += int'(ls_done[1]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pulse_cnt += int'(ls_done[1]);
    chk("rstmid_no_done", 32'(pulse_cnt), 0);
    chk("rstmid_idle_after", 32'(busy[1]), 0);
    @(posedge clk); #1;
    do_access(1, 0, 0, 32'd3, 32'h0, pk, np, enc, rwc, got, pa, dw, e1);
    $display("post-reset load dut1 pulse@%0d data=%h", pk, got);
    chk("rstmid_next_pulse", 32'(pk), 5);
    chk("rstmid_next_data", got, 32'hCAFE_F00D);

    // Random traffic on the MEM_LAT=1 instance against a cycle-time schedule model.
    f_pend = 0; d_pend = 0; f_rel = 0; d_rel = 0; last_data = 0;
    d_we = 0; f_pc = 0; d_addr = 0; d_wdata = 0;
    cur_data = 0; cur_we = 0; cur_addr = 0; cur_wdata = 0; exp_val = 0;
    next_idle = 0; grant = -100; done = -100;
    for (int c = 0; c < 400; c++) begin
      if (f_rel) begin f_pend = 0; f_rel = 0; end
      if (d_rel) begin d_pend = 0; d_rel = 0; end
      if (!f_pend && $urandom_range(0, 2) != 0) begin
        f_pend = 1; f_pc = 32'($urandom_range(0, 15));
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)); d_wdata = $urandom;
      end
      if_req[0] = f_pend; if_pc[0] = f_pc;
      ls_req[0] = d_pend; ls_we[0] = d_we; ls_addr[0] = d_addr; ls_wdata[0] = d_wdata;
      if (c == next_idle) begin
        if (f_pend || d_pend) begin
          cur_data  = d_pend && (!f_pend || !last_data);
          cur_we    = cur_data && d_we;
          cur_addr  = cur_data ? d_addr : f_pc;
          cur_wdata = d_wdata;
          grant     = c;
          done      = c + (cur_we ? 2 : 2 + LAT0);
          next_idle = done + 1;
          exp_val   = model_mem[0][cur_addr[3:0]];
        end else begin
          next_idle = c + 1;
        end
      end
      @(negedge clk);
      chk("rnd_busy", 32'(busy[0]), 32'(c > grant && c <= done));
      chk("rnd_if_ready", 32'(if_ready[0]), 32'(c == done && !cur_data));
      chk("rnd_ls_done", 32'(ls_done[0]), 32'(c == done && cur_data));
      chk("rnd_op2en", 32'(op2en[0]),
          32'(cur_data && c >= grant + 1 && c <= (cur_we ? grant + 1 : grant + 1 + LAT0)));
      chk("rnd_op2rw", 32'(op2rw[0]), 32'(cur_we && c == grant + 1));
      if (c == grant + 1) begin
        if (cur_data) chk("rnd_rwaddr", rw_addr[0], cur_addr);
        else          chk("rnd_readpc", read_pc[0], cur_addr);
        if (cur_we)   chk("rnd_datawrite", data_wr[0], cur_wdata);
      end
      if (c == done) begin
        $display("rnd cycle %0d %s addr=%0d value=%h", c,
                 cur_data ? (cur_we ? "store" : "load ") : "fetch", cur_addr,
                 cur_we ? cur_wdata : exp_val);
        if (cur_data) begin
          if (cur_we) model_mem[0][cur_addr[3:0]] = cur_wdata;
          else        chk("rnd_ls_rdata", ls_rdata[0], exp_val);
          d_rel = 1; last_data = 1;
        end else begin
          chk("rnd_if_instr", if_instr[0], exp_val);
          f_rel = 1; last_data = 0;
        end
      end
      @(posedge clk); #1;
    end
    if_req[0] = 0; ls_req[0] = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
